// File: rtl/dm_arbiter.sv
// Two-requester arbiter sharing one line-wide memory port; registered outputs, one-cycle acks.
// Round-robin by default; define DM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module dm_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [LINE_W-1:0] m0_data_i,
  output logic              m0_ack_o,
  output logic [LINE_W-1:0] m0_data_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [LINE_W-1:0] m1_data_i,
  output logic              m1_ack_o,
  output logic [LINE_W-1:0] m1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state, state_nxt;
  logic   grant;
  logic   winner;
  logic   take;
  logic   done;

`ifdef DM_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = ~m0_enable_i;
  end
`else
  logic last;

  // On a tie the requester that was not served most recently wins.
  always_comb begin
    if (m0_enable_i && m1_enable_i) winner = ~last;
    else                            winner = ~m0_enable_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)    last <= 1'b1;
    else if (take) last <= winner;
  end
`endif

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (m0_enable_i || m1_enable_i) begin
          take      = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          done      = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      grant        <= 1'b0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      m0_ack_o     <= 1'b0;
      m1_ack_o     <= 1'b0;
      m0_data_o    <= '0;
      m1_data_o    <= '0;
    end else begin
      m0_ack_o <= done && !grant;
      m1_ack_o <= done &&  grant;
      if (take) begin
        grant        <= winner;
        mem_enable_o <= 1'b1;
        mem_write_o  <= winner ? m1_write_i : m0_write_i;
        mem_addr_o   <= winner ? m1_addr_i  : m0_addr_i;
        mem_data_o   <= winner ? m1_data_i  : m0_data_i;
      end
      if (done) begin
        mem_enable_o <= 1'b0;
        // Write completions leave the requester's read line untouched.
        if (!mem_write_o) begin
          if (grant) m1_data_o <= mem_data_i;
          else       m0_data_o <= mem_data_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: cycle vector table plus reset and tie sequences.
module tb_dm_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_en, m0_wr, m1_en, m1_wr;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [LW-1:0] m0_wdat, m1_wdat;
  logic          m0_ack, m1_ack;
  logic [LW-1:0] m0_rdat, m1_rdat;
  logic          mem_en, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdat;
  logic          mem_ack;
  logic [LW-1:0] mem_rdat;

  always #5 clk = ~clk;

  dm_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .m0_enable_i(m0_en), .m0_write_i(m0_wr), .m0_addr_i(m0_addr), .m0_data_i(m0_wdat),
    .m0_ack_o(m0_ack), .m0_data_o(m0_rdat),
    .m1_enable_i(m1_en), .m1_write_i(m1_wr), .m1_addr_i(m1_addr), .m1_data_i(m1_wdat),
    .m1_ack_o(m1_ack), .m1_data_o(m1_rdat),
    .mem_enable_o(mem_en), .mem_write_o(mem_wr), .mem_addr_o(mem_addr), .mem_data_o(mem_wdat),
    .mem_ack_i(mem_ack), .mem_data_i(mem_rdat)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " mem_enable"}, LW'(mem_en), '0);
    chk({tag, " mem_write"}, LW'(mem_wr), '0);
    chk({tag, " mem_addr"}, LW'(mem_addr), '0);
    chk({tag, " mem_data"}, mem_wdat, '0);
    chk({tag, " m0_ack"}, LW'(m0_ack), '0);
    chk({tag, " m1_ack"}, LW'(m1_ack), '0);
    chk({tag, " m0_data"}, m0_rdat, '0);
    chk({tag, " m1_data"}, m1_rdat, '0);
  endtask

  typedef struct {
    logic        m0_en, m1_en, mack;
    logic [15:0] rdata;
    logic        e_men, e_mwr;
    logic [7:0]  e_addr;
    logic [15:0] e_mdat;
    logic        e_a0, e_a1;
    logic [15:0] e_d0, e_d1;
  } vec_t;

  vec_t vt[22];
  logic exp_seq[5];
  logic w;
  logic [15:0] rd;

  initial begin
    // m0 reads addr 0x0 (10-cycle memory), m1 writes 0xA5A5 to 0x40, spurious ack in IDLE, m0 reads again.
    for (int i = 0; i < 10; i++) vt[i] = '{1,0,0,16'h0, 1,0,8'h00,16'h0, 0,0,16'h0,16'h0};
    vt[10] = '{1,0,1,16'h0005, 0,0,8'h00,16'h0,    1,0,16'h5,16'h0};
    vt[11] = '{0,0,0,16'h0,    0,0,8'h00,16'h0,    0,0,16'h5,16'h0};
    for (int i = 12; i < 15; i++) vt[i] = '{0,1,0,16'h0, 1,1,8'h40,16'hA5A5, 0,0,16'h5,16'h0};
    vt[15] = '{0,1,1,16'hFFFF, 0,1,8'h40,16'hA5A5, 0,1,16'h5,16'h0};
    vt[16] = '{0,0,0,16'h0,    0,1,8'h40,16'hA5A5, 0,0,16'h5,16'h0};
    vt[17] = '{0,0,1,16'hBEEF, 0,1,8'h40,16'hA5A5, 0,0,16'h5,16'h0};
    vt[18] = '{0,0,0,16'h0,    0,1,8'h40,16'hA5A5, 0,0,16'h5,16'h0};
    vt[19] = '{1,0,0,16'h0,    1,0,8'h00,16'h0,    0,0,16'h5,16'h0};
    vt[20] = '{1,0,1,16'h1234, 0,0,8'h00,16'h0,    1,0,16'h1234,16'h0};
    vt[21] = '{0,0,0,16'h0,    0,0,8'h00,16'h0,    0,0,16'h1234,16'h0};
`ifdef DM_ARB_FIXED_PRIO_EN
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif

    rst_n = 1'b0;
    m0_en = 0; m0_wr = 0; m0_addr = '0; m0_wdat = '0;
    m1_en = 0; m1_wr = 1; m1_addr = 32'h40; m1_wdat = LW'(16'hA5A5);
    mem_ack = 0; mem_rdat = '0;
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      m0_en = vt[i].m0_en; m1_en = vt[i].m1_en;
      mem_ack = vt[i].mack; mem_rdat = LW'(vt[i].rdata);
      @(posedge clk); #1;
      chk($sformatf("row%0d mem_enable", i), LW'(mem_en), LW'(vt[i].e_men));
      chk($sformatf("row%0d mem_write", i), LW'(mem_wr), LW'(vt[i].e_mwr));
      chk($sformatf("row%0d mem_addr", i), LW'(mem_addr), LW'(vt[i].e_addr));
      chk($sformatf("row%0d mem_data", i), mem_wdat, LW'(vt[i].e_mdat));
      chk($sformatf("row%0d m0_ack", i), LW'(m0_ack), LW'(vt[i].e_a0));
      chk($sformatf("row%0d m1_ack", i), LW'(m1_ack), LW'(vt[i].e_a1));
      chk($sformatf("row%0d m0_data", i), m0_rdat, LW'(vt[i].e_d0));
      chk($sformatf("row%0d m1_data", i), m1_rdat, LW'(vt[i].e_d1));
    end

    // Reset mid-transaction: outputs clear without a clock edge, no ack, request re-granted after release.
    @(negedge clk);
    m0_en = 1; m0_wr = 0; m0_addr = 32'h80; mem_ack = 0;
    @(posedge clk); #1;
    chk("rst pre grant", LW'(mem_en), LW'(1'b1));
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async rst");
    @(posedge clk); #1;
    chk("rst hold mem_enable", LW'(mem_en), '0);
    chk("rst hold m0_ack", LW'(m0_ack), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post rst regrant", LW'(mem_en), LW'(1'b1));
    chk("post rst addr", LW'(mem_addr), LW'(32'h80));
    @(negedge clk);
    mem_ack = 1; mem_rdat = LW'(16'h0077);
    @(posedge clk); #1;
    chk("post rst m0_ack", LW'(m0_ack), LW'(1'b1));
    chk("post rst m0_data", m0_rdat, LW'(16'h0077));
    @(negedge clk);
    mem_ack = 0; m0_en = 0;
    @(posedge clk); #1;
    chk("post rst ack pulse", LW'(m0_ack), '0);

    // Tie: both requesters held, each re-requests right after its ack cycle.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    m0_addr = 32'h100; m1_addr = 32'h200; m1_wr = 0;
    m0_en = 1; m1_en = 1;
    @(posedge clk); #1;
    chk("tie grant0 enable", LW'(mem_en), LW'(1'b1));
    chk("tie grant0 addr", LW'(mem_addr), LW'(exp_seq[0] ? 32'h200 : 32'h100));
    for (int t = 0; t < 5; t++) begin
      w  = exp_seq[t];
      rd = 16'h0300 + 16'(t);
      repeat (2) @(posedge clk);
      @(negedge clk);
      mem_ack = 1; mem_rdat = LW'(rd);
      @(posedge clk); #1;
      chk($sformatf("tie%0d m0_ack", t), LW'(m0_ack), LW'(!w));
      chk($sformatf("tie%0d m1_ack", t), LW'(m1_ack), LW'(w));
      chk($sformatf("tie%0d data", t), w ? m1_rdat : m0_rdat, LW'(rd));
      chk($sformatf("tie%0d gap1", t), LW'(mem_en), '0);
      @(negedge clk);
      mem_ack = 0;
      if (w) m1_en = 0; else m0_en = 0;
      @(posedge clk); #1;
      chk($sformatf("tie%0d gap2", t), LW'(mem_en), '0);
      chk($sformatf("tie%0d ack clear", t), LW'({m0_ack, m1_ack}), '0);
      @(negedge clk);
      if (w) m1_en = 1; else m0_en = 1;
      @(posedge clk); #1;
      chk($sformatf("tie%0d regrant", t), LW'(mem_en), LW'(1'b1));
      if (t < 4)
        chk($sformatf("tie%0d next addr", t), LW'(mem_addr), LW'(exp_seq[t+1] ? 32'h200 : 32'h100));
    end
    @(negedge clk);
    m0_en = 0; m1_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-requester arbiter sharing the single 256-bit-line `Data_Memory` port between the instruction-cache and data-cache miss paths. Each requester issues a level-held enable/write/address/data request. The arbiter grants one requester at a time and forwards its request to memory. It waits for the memory's `ack`, then returns a one-cycle ack and the registered read line to the granted requester. Round-robin arbitration by default; fixed priority when configured.

## Interface
Parameters:
- ADDR_W, 32, address width
- LINE_W, 256, line width (memory data bus)

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- m0_enable_i  in  1  requester 0 request (held until m0_ack_o)
- m0_write_i  in  1  requester 0 write (1) / read (0)
- m0_addr_i  in  ADDR_W  requester 0 address
- m0_data_i  in  LINE_W  requester 0 write line
- m0_ack_o  out  1  requester 0 completion pulse
- m0_data_o  out  LINE_W  requester 0 read line
- m1_enable_i, m1_write_i, m1_addr_i, m1_data_i, m1_ack_o, m1_data_o: same as m0, for requester 1
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  memory write
- mem_addr_o  out  ADDR_W  memory address
- mem_data_o  out  LINE_W  memory write line
- mem_ack_i  in  1  memory completion (one-cycle pulse)
- mem_data_i  in  LINE_W  memory read line, valid with mem_ack_i

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - If any `mN_enable_i` is high at the edge, pick the winner and latch its write/addr/data into the `mem_*` registers.
  - Set `mem_enable_o` = 1, set `grant` = winner, go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY**
  - Hold all `mem_*` outputs stable.
  - On `mem_ack_i` = 1:
    - clear `mem_enable_o`;
    - if read, latch `mem_data_i` into `m<grant>_data_o`;
    - set `m<grant>_ack_o` = 1;
    - go to RESP.
- **RESP**
  - Clear the ack (pulse is exactly one cycle).
  - Go to IDLE unconditionally.
  - Requests are not sampled in RESP.
- **Round-robin**
  - `last` register records the most recent grant.
  - When both requesters are high, the one not equal to `last` wins.
  - When only one is high, that one wins.
- **Write completion:** `mN_data_o` is unchanged.
- `mN_data_o` holds its value until the next read completion for that requester.
- **Requester rules:** keep enable and all inputs stable until its ack, and drop enable in the ack cycle.
  - Enable dropped early: the transaction still completes and the ack still pulses.
- `mem_ack_i` in IDLE or RESP is ignored.
- **Reset (async, rst_i = 0), including mid-transaction:**
  - state goes to IDLE;
  - all outputs go to 0 (`mem_enable_o`, `mem_write_o`, `mem_addr_o`, `mem_data_o`, both acks, both data outs);
  - `last` goes to 1, so requester 0 wins the first tie.
  - An in-flight request is abandoned without ack; the requester re-issues it after reset.

## Timing
- Request sampled at edge k → `mem_enable_o` high from edge k.
- `mem_ack_i` high in cycle ending at edge k+L → `mN_ack_o` high for one cycle after edge k+L, with `mN_data_o` valid.
- → `mem_enable_o` low from edge k+L for at least 2 cycles (RESP plus the IDLE sample).
- Back-to-back: the next grant occurs at the IDLE edge, 2 edges after the memory ack.
- A held request from the other requester is granted at that edge.
- Throughput: one transaction per L+2 cycles minimum.
- No combinational path from any input to any output; all outputs are registered.

## Configuration
- `DM_ARB_FIXED_PRIO_EN` defined:
  - requester 0 always wins ties;
  - `last` is not used;
  - requester 1 can starve under continuous requester-0 traffic.
- Not defined: round-robin as above.
- Reset, handshake and timing are identical in both builds.

## Test plan
- **Reset:** reset mid-BUSY with `m0_enable_i` = 1 → all outputs 0 asynchronously; no ack. After release, m0 is re-granted at the first edge and `mem_enable_o` = 1.
- **Single read:** m0 read addr 0x0, memory acks 10 cycles later with data 0x5 → `m0_ack_o` pulses once, the cycle after `mem_ack_i`; `m0_data_o` = 0x5 and stays 0x5; `m1_ack_o` stays 0.
- **Write:** m1 write addr 0x40, data 0xA5A5 → `mem_write_o` = 1, `mem_addr_o` = 0x40, `mem_data_o` = 0xA5A5 while BUSY; `m1_ack_o` pulses once; `m1_data_o` unchanged.
- **Tie, round-robin:** m0 and m1 assert in the same cycle after reset, both held → grant order m0, m1, m0. `mem_enable_o` is low for exactly 2 cycles between transactions.
- **Tie, `DM_ARB_FIXED_PRIO_EN`:** m0 re-requests each time it is acked while m1 is held → m1 is never acked over 5 transactions.
- **Spurious ack:** `mem_ack_i` pulsed in IDLE → no `mN_ack_o`; state stays IDLE.
